// File: rtl/async_fifo_fwft.sv
// Dual-clock FIFO with gray-pointer crossing, optional first-word-fall-through
// output, occupancy counts in both domains, almost flags and sticky error flags.
`timescale 1ns/1ps
module async_fifo_fwft #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1,
  parameter int AF_LEVEL    = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                  fifo_rd_clk,
  input  logic                  fifo_wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_data_count,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_data_count,
  output logic                  rd_underflow
);
  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AF_LV = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LV = (AW+1)'(AE_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, rgray_s;
  logic [AW:0] wcnt_q, wcnt_d;
  logic        wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d, wr_acc;
  logic [SYNC_STAGES-1:0][AW:0] rsync_q;

  // ---------------- read domain -----------------
  // rbin tracks RAM fetches; cbin tracks words actually consumed by the reader.
  // Only cbin (as gray) is sent back, so a word parked in the FWFT output
  // register still holds its slot from the writer's point of view.
  logic [AW:0] rbin_q, rbin_d, cbin_q, cbin_d, rgray_q, wgray_s, wbin_s;
  logic [AW:0] rcnt_q, rcnt_d;
  logic        rempty_q, rempty_d, vld_q, vld_d, rae_q, rae_d, ruf_q, ruf_d;
  logic        ram_ne, pop, consume;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0][AW:0] wsync_q;

  assign rgray_s = rsync_q[SYNC_STAGES-1];
  assign wgray_s = wsync_q[SYNC_STAGES-1];
  assign wbin_s  = gray2bin(wgray_s);

  // Write-side next state: full/count/almost-full all look at the post-write pointer.
  always_comb begin
    wr_acc  = wr_en && !wfull_q;
    wbin_d  = wbin_q + (AW+1)'(wr_acc);
    wgray_d = bin2gray(wbin_d);
    wfull_d = (wgray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
    wcnt_d  = wbin_d - gray2bin(rgray_s);
    waf_d   = (wcnt_d >= AF_LV);
    wovf_d  = wovf_q | (wr_en & wfull_q);
  end

  // Write-domain state registers.
  always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
      wcnt_q  <= '0;
      waf_q   <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
      wcnt_q  <= wcnt_d;
      waf_q   <= waf_d;
      wovf_q  <= wovf_d;
    end
  end

  // Storage: no reset, written only on accepted writes.
  always_ff @(posedge fifo_wr_clk) begin
    if (wr_acc) mem[wbin_q[AW-1:0]] <= wr_data;
  end

  // Read gray pointer into the write clock.
  always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
    if (!rst_n) rsync_q <= '0;
    else        rsync_q <= {rsync_q[SYNC_STAGES-2:0], rgray_q};
  end

  // Write gray pointer into the read clock.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) wsync_q <= '0;
    else        wsync_q <= {wsync_q[SYNC_STAGES-2:0], wgray_q};
  end

  // Read-side next state for both FWFT and standard modes.
  always_comb begin
    ram_ne = (rbin_q != wbin_s);
    if (FWFT != 0) begin
      // Output register refills itself whenever it is free or being drained.
      consume  = rd_en && vld_q;
      pop      = ram_ne && (!vld_q || rd_en);
      vld_d    = pop || (vld_q && !rd_en);
      rbin_d   = rbin_q + (AW+1)'(pop);
      rempty_d = !vld_d;
      ruf_d    = ruf_q | (rd_en & !vld_q);
    end else begin
      pop      = rd_en && !rempty_q;
      consume  = pop;
      vld_d    = pop;
      rbin_d   = rbin_q + (AW+1)'(pop);
      rempty_d = (bin2gray(rbin_d) == wgray_s);
      ruf_d    = ruf_q | (rd_en & rempty_q);
    end
    cbin_d  = cbin_q + (AW+1)'(consume);
    rdata_d = pop ? mem[rbin_q[AW-1:0]] : rdata_q;
    rcnt_d  = wbin_s - cbin_d;
    rae_d   = (rcnt_d <= AE_LV);
  end

  // Read-domain state registers.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q   <= '0;
      cbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      vld_q    <= 1'b0;
      rcnt_q   <= '0;
      rae_q    <= 1'b1;
      ruf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      cbin_q   <= cbin_d;
      rgray_q  <= bin2gray(cbin_d);
      rempty_q <= rempty_d;
      vld_q    <= vld_d;
      rcnt_q   <= rcnt_d;
      rae_q    <= rae_d;
      ruf_q    <= ruf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wr_full         = wfull_q;
  assign wr_almost_full  = waf_q;
  assign wr_data_count   = wcnt_q;
  assign wr_overflow     = wovf_q;
  assign rd_data         = rdata_q;
  assign rd_valid        = vld_q;
  assign rd_empty        = rempty_q;
  assign rd_almost_empty = rae_q;
  assign rd_data_count   = rcnt_q;
  assign rd_underflow    = ruf_q;
endmodule
